// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed driver for a DIGITS-wide common-anode
// seven-segment display. It latches a packed hex value and scans one digit
// per CLK_DIV clocks. It adds leading-zero blanking, per-digit decimal points
// and frame-synchronous (tear-free) updates of the displayed value.
module hex_scan_display #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            segs,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEGS_OFF  = 7'b1111111;

  // Scan position
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Displayed (shadow) and staged values
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] stage_val_q, stage_val_d;
  logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic                pending_q, pending_d;

  // Registered outputs
  logic [6:0]          segs_q, segs_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                wrap_q;
  logic                frame_done_q;

  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  // Active-low a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Advance the tick/digit counters while scanning; park them at 0 when disabled.
  always_comb begin
    wrap   = enable && (tick_q == TICK_LAST) && (idx_q == IDX_LAST);
    tick_d = tick_q;
    idx_d  = idx_q;
    if (!enable) begin
      tick_d = '0;
      idx_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // Decide shadow/staging updates: direct when dark, frame-synchronous when scanning.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    stage_val_d  = stage_val_q;
    stage_dp_d   = stage_dp_q;
    pending_d    = pending_q;
    if (!enable) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_in;
      end
    end else if (wrap) begin
      // A load landing on the wrap edge beats anything already staged.
      pending_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_in;
      end else if (pending_q) begin
        shadow_val_d = stage_val_q;
        shadow_dp_d  = stage_dp_q;
      end
    end else if (load) begin
      stage_val_d = value;
      stage_dp_d  = dp_in;
      pending_d   = 1'b1;
    end
  end

  // Select the current digit's nibble, dp bit, anode and blanking state.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = shadow_val_q[4*k +: 4];
        cur_dp    = shadow_dp_q[k];
        an_d[k]   = 1'b0;
        cur_blank = blank_lz && (k != 0) && ((shadow_val_q >> (4*k)) == '0);
      end
    end
  end

  // Next output values: dark when disabled, otherwise the decoded current digit.
  always_comb begin
    if (!enable) begin
      segs_d = SEGS_OFF;
      dp_d   = 1'b1;
    end else begin
      segs_d = cur_blank ? SEGS_OFF : hex_to_segs(cur_nib);
      dp_d   = ~cur_dp;
    end
  end

  // Scan counters and value storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      stage_val_q  <= '0;
      stage_dp_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      stage_val_q  <= stage_val_d;
      stage_dp_q   <= stage_dp_d;
      pending_q    <= pending_d;
    end
  end

  // Output registers; frame_done is delayed twice so it lines up with digit 0 appearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs_q       <= SEGS_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      an_q         <= enable ? an_d : '1;
      wrap_q       <= wrap;
      frame_done_q <= enable && wrap_q;
    end
  end

  assign segs       = segs_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Testbench for hex_scan_display (DIGITS = 4, CLK_DIV = 4): a frame-counting
// reference model checked every cycle, plus hand-computed literal checks.
module tb_hex_scan_display;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int seen_bad = 0;
  bit watch = 1'b0;

  hex_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .segs(segs), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Seven-segment table, active-low a..g.
  logic [6:0] SEG [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cnt = clock edges seen while enabled; digit and wrap follow by arithmetic.
  int          m_cnt;
  logic [15:0] m_shadow, m_stage;
  logic [3:0]  m_sdp, m_sdps;
  bit          m_pend, m_wrapped;
  logic [6:0]  e_segs;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  function automatic int f_idx(input int cnt);
    return (cnt / CLK_DIV) % DIGITS;
  endfunction

  function automatic bit f_wrap(input int cnt);
    return (cnt % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [6:0] f_segs(input logic [15:0] sh, input int id, input logic blz);
    logic [15:0] upper;
    upper = sh >> (4 * id);
    if (blz && id != 0 && upper == 16'h0) return 7'h7F;
    return SEG[upper[3:0]];
  endfunction

  function automatic logic [3:0] f_an(input int id);
    logic [3:0] a;
    a = 4'hF;
    a[id] = 1'b0;
    return a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_shadow <= '0; m_stage <= '0; m_sdp <= '0; m_sdps <= '0;
      m_pend <= 1'b0; m_wrapped <= 1'b0;
      e_segs <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_fd <= 1'b0;
    end else begin
      if (enable) begin
        e_an   <= f_an(f_idx(m_cnt));
        e_segs <= f_segs(m_shadow, f_idx(m_cnt), blank_lz);
        e_dp   <= ~m_sdp[f_idx(m_cnt)];
      end else begin
        e_an <= 4'hF; e_segs <= 7'h7F; e_dp <= 1'b1;
      end
      e_fd      <= enable && m_wrapped;
      m_wrapped <= enable && f_wrap(m_cnt);
      if (!enable) begin
        m_pend <= 1'b0;
        if (load) begin m_shadow <= value; m_sdp <= dp_in; end
      end else if (f_wrap(m_cnt)) begin
        m_pend <= 1'b0;
        if (load) begin m_shadow <= value; m_sdp <= dp_in; end
        else if (m_pend) begin m_shadow <= m_stage; m_sdp <= m_sdps; end
      end else if (load) begin
        m_stage <= value; m_sdps <= dp_in; m_pend <= 1'b1;
      end
      m_cnt <= enable ? m_cnt + 1 : 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("segs", segs, e_segs);
    check("dp", dp, e_dp);
    check("an", an, e_an);
    check("frame_done", frame_done, e_fd);
  end

  // Watch for the digit patterns of the overwritten 1111/2222 loads.
  always @(posedge clk) begin
    #1;
    if (watch && (segs == 7'h4F || segs == 7'h12)) seen_bad <= seen_bad + 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_digit(input int k);
    logic [3:0] want;
    bit ok;
    want = f_an(k);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (an == want) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_digit_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_segs"}, segs, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_fd"}, frame_done, 1'b0);
  endtask

  initial begin
    int c1;
    bit ok;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_dark("reset");
    @(negedge clk) rst_n = 1'b1;

    // 1: free scan of the all-zero reset value
    @(negedge clk) enable = 1'b1;
    wait_digit(0); check("t1_d0_segs", segs, 7'h01);
    wait_digit(1); check("t1_d1_an", an, 4'b1101);
    wait_digit(3); check("t1_d3_segs", segs, 7'h01);
    wait_fd(); c1 = cyc;
    wait_fd(); check("t1_frame_period", cyc - c1, FRAME);

    // 2: load while dark, then scan 1A3F with dp on digit 1
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1 check_dark("t2_dark");
    do_load(16'h1A3F, 4'b0010);
    @(negedge clk) enable = 1'b1;
    wait_digit(0); check("t2_d0_segs", segs, 7'h38); check("t2_d0_dp", dp, 1'b1);
    wait_digit(1); check("t2_d1_segs", segs, 7'h06); check("t2_d1_dp", dp, 1'b0);
    wait_digit(2); check("t2_d2_segs", segs, 7'h08);
    wait_digit(3); check("t2_d3_segs", segs, 7'h4F);

    // 3: mid-frame load is deferred to the next frame
    wait_digit(1);
    do_load(16'h0000, 4'b0000);
    wait_digit(2); check("t3_d2_old", segs, 7'h08);
    wait_digit(3); check("t3_d3_old", segs, 7'h4F);
    wait_fd(); check("t3_fd_an", an, 4'b1110); check("t3_d0_new", segs, 7'h01);
    wait_digit(1); check("t3_d1_new", segs, 7'h01); check("t3_d1_dp", dp, 1'b1);

    // 4: leading-zero blanking
    @(negedge clk) begin enable = 1'b0; blank_lz = 1'b1; end
    do_load(16'h0040, 4'b0000);
    @(negedge clk) enable = 1'b1;
    wait_digit(0); check("t4_d0", segs, 7'h01);
    wait_digit(1); check("t4_d1", segs, 7'h4C);
    wait_digit(2); check("t4_d2_blank", segs, 7'h7F);
    wait_digit(3); check("t4_d3_blank", segs, 7'h7F); check("t4_d3_an", an, 4'b0111);
    @(negedge clk) enable = 1'b0;
    do_load(16'h0000, 4'b0000);
    @(negedge clk) enable = 1'b1;
    wait_digit(0); check("t4z_d0", segs, 7'h01);
    wait_digit(1); check("t4z_d1", segs, 7'h7F);
    wait_digit(2); check("t4z_d2", segs, 7'h7F);
    wait_digit(3); check("t4z_d3", segs, 7'h7F);

    // 5: newest load wins, load on the wrap edge goes straight to shadow
    @(negedge clk) begin enable = 1'b0; blank_lz = 1'b0; end
    @(negedge clk) begin
      watch = 1'b1; enable = 1'b1; value = 16'h1111; load = 1'b1;
    end
    @(negedge clk) load = 1'b0;
    @(negedge clk) begin value = 16'h2222; load = 1'b1; end
    @(negedge clk) load = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f_wrap(m_cnt)) begin ok = 1'b1; break; end
    end
    if (!ok) check("t5_wrap_timeout", 32'd0, 32'd1);
    value = 16'h3333; load = 1'b1;
    @(negedge clk) load = 1'b0;
    wait_fd(); check("t5_d0", segs, 7'h06); check("t5_d0_an", an, 4'b1110);
    wait_digit(1); check("t5_d1", segs, 7'h06);
    wait_digit(2); check("t5_d2", segs, 7'h06);
    wait_digit(3); check("t5_d3", segs, 7'h06);
    watch = 1'b0;
    check("t5_never_1111_2222", seen_bad, 0);

    // 6: asynchronous reset with a load pending
    wait_digit(1);
    do_load(16'h4444, 4'b1111);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_dark("t6_async");
    @(negedge clk) rst_n = 1'b1;
    wait_digit(0); check("t6_d0", segs, 7'h01); check("t6_d0_dp", dp, 1'b1);
    wait_digit(2); check("t6_d2", segs, 7'h01);
    wait_fd(); check("t6_next_d0", segs, 7'h01);
    wait_digit(3); check("t6_next_d3", segs, 7'h01); check("t6_next_d3_dp", dp, 1'b1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It is the parametrised successor to the single-digit hex decoder.
- Latches a packed hex value and scans one digit at a time at a programmable refresh rate.
- Decodes each nibble to segments and drives per-digit active-low anode enables.
- Adds leading-zero blanking, per-digit decimal points and tear-free (frame-synchronous) updates.
- Sits between datapath status registers and board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 50000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan running; 0 = display dark
value  input  4*DIGITS  packed hex value; nibble k (value[4k+3:4k]) shown on digit k, digit 0 = least significant
dp_in  input  DIGITS  decimal point request per digit, 1 = lit
load  input  1  single-cycle strobe: capture value/dp_in
blank_lz  input  1  1 = blank leading zero digits
segs  output  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-low
dp  output  1  decimal point, active-low
an  output  DIGITS  digit enables, active-low, one-hot-low when lit
frame_done  output  1  one-cycle pulse when scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset state:
  - tick = 0, idx = 0.
  - shadow, staged value and dp = 0; pending = 0.
  - segs = 7'b1111111, dp = 1, an = all ones, frame_done = 0.
- Tick counter:
  - While enable = 1, tick counts 0..CLK_DIV-1.
  - At CLK_DIV-1, tick returns to 0 and idx advances (idx DIGITS-1 wraps to 0).
- enable = 0:
  - tick and idx are held at 0; pending is cleared.
  - All outputs go dark (segs 1111111, dp 1, an all ones) on the next edge.
- Load:
  - load while enable = 0: shadow <= value/dp_in on that edge.
  - load while enable = 1: value is staged and pending = 1. Shadow updates only on the wrap edge (idx DIGITS-1 -> 0), and pending clears there.
  - A new load while pending overwrites the staged value (newest wins).
  - load on the wrap edge itself: the incoming value goes directly to shadow; pending ends 0.
- Outputs are registered every cycle from current idx/shadow, so they lag idx by exactly one cycle.
  - an = all ones except bit idx = 0.
  - segs = decode(shadow nibble idx).
  - dp = ~shadow_dp[idx].
- frame_done is registered: high for the one cycle following the wrap edge, aligned with the outputs first showing digit 0.
- Decode (active-low, a..g):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Leading-zero blanking (blank_lz = 1):
  - Digit k is blanked (segs 1111111) when all nibbles k..DIGITS-1 of shadow are 0 and k != 0.
  - Digit 0 is never blanked.
  - an for a blanked digit still toggles; dp is unaffected by blanking.
  - blank_lz is sampled live, not latched.
- Reset mid-scan: immediately returns to the reset state; any staged value is lost.

Test Plan:
1. Reset then enable = 1, CLK_DIV = 4, DIGITS = 4, no load -> an cycles 1110, 1101, 1011, 0111 every 4 clocks; segs = 0000001 on all digits; frame_done pulses every 16 clocks.
2. enable = 0, load value = 16'h1A3F, dp_in = 4'b0010, then enable = 1 -> digit 0 segs 0111000 (F), digit 1 0000110 with dp = 0, digit 2 0001000, digit 3 1001111.
3. Mid-frame load value = 16'h0000 while showing 16'h1A3F -> the remaining digits of the current frame still show 1A3F; the next frame (after frame_done) shows all zeros.
4. blank_lz = 1, value 16'h0040 -> digits 3 and 2 segs 1111111, digit 1 1001100, digit 0 0000001; with value 16'h0000 only digit 0 is lit (0000001).
5. Two loads in one frame (16'h1111 then 16'h2222), plus a load of 16'h3333 exactly on the wrap edge -> the next frame shows 3333; 1111 never appears.
6. Assert rst_n = 0 mid-frame with a load pending -> outputs dark asynchronously; after release the display shows 0000 and the pending value is discarded.
